branch_pred_queue: RTL and testbench
====================================

# branch_pred_queue

Holds fetch-stage branch predictions in order until each branch resolves in execute. Compares the stored prediction with the actual outcome and raises a same-cycle mispredict with the recovery PC. Emits a registered counter-update record for the direction predictor. Sits between the fetch-side predictor (producer of predictions) and the execute-stage branch comparator (consumer/resolver).

## Interface
- DATA_WIDTH, 32, PC/address width
- DEPTH, 4, queue entries (power of two, ≥2)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- PredValidF  in  1  branch fetched this cycle; push request
- PredTakenF  in  1  predicted direction (1 = taken)
- PCF  in  DATA_WIDTH  PC of fetched branch
- PCTargetF  in  DATA_WIDTH  branch target (PCF + B-immediate)
- BranchE  in  1  branch in execute this cycle; pop request
- BranchTakenE  in  1  actual outcome, valid when BranchE=1
- MispredictE  out  1  combinational; BranchE & head valid & (head.taken != BranchTakenE)
- RecoveryPCE  out  DATA_WIDTH  combinational; head.taken ? head.PC+4 : head.target; 0 when queue empty
- QueueFull  out  1  count == DEPTH
- QueueEmpty  out  1  count == 0
- UpdValid  out  1  registered; one-cycle pulse per resolved branch
- UpdBackward  out  1  registered; resolved branch was backward (target < PC, unsigned)
- UpdTaken  out  1  registered; actual outcome of resolved branch
- OverflowErr  out  1  sticky; push dropped while full
- UnderflowErr  out  1  sticky; BranchE while empty

## Operation
- Entry = {taken, backward, PC, target}. Backward is computed at push time: PCTargetF < PCF, unsigned.
- Circular buffer: head pointer, tail pointer, count of clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Push is accepted when PredValidF=1 and (count<DEPTH or a pop happens the same cycle) and there is no mispredict this cycle.
- Pop happens when BranchE=1 and count>0.
- Push and pop in the same cycle: both take effect and count is unchanged. When full, a simultaneous push+pop is accepted.
- Push while full without a pop: entry dropped, OverflowErr set, state unchanged.
- BranchE while empty: no pop, MispredictE=0, UpdValid stays 0 next cycle, UnderflowErr set.
- Mispredict: head is consumed and all younger entries are wrong-path. Next state is count=0 and head=tail (tail keeps its value). Any same-cycle push is discarded without setting OverflowErr.
- Correct prediction: normal pop only.
- Update record is registered from the head on every valid pop: UpdValid=1 the following cycle, with that entry's backward bit and BranchTakenE.
- PC+4 arithmetic is modulo 2^DATA_WIDTH; the carry out is discarded.
- Error flags clear only on rst.

## Timing
- Reset (async assert, cleared on deassertion): head=tail=count=0; QueueEmpty=1, QueueFull=0; UpdValid=UpdBackward=UpdTaken=0; OverflowErr=UnderflowErr=0; MispredictE=0; RecoveryPCE=0.
- Push latency: an entry pushed in cycle N is the head no earlier than cycle N+1. Simultaneous push into an empty queue and BranchE does not bypass; it is treated as BranchE-while-empty.
- MispredictE/RecoveryPCE: zero-cycle, combinational from head and BranchE/BranchTakenE.
- QueueFull/QueueEmpty reflect registered count (post-edge value).
- UpdValid: exactly one cycle after the pop edge, one cycle wide; back-to-back pops give back-to-back pulses.
- rst asserted mid-operation: all entries are dropped immediately and no UpdValid follows.

## Test plan
- Reset then idle: QueueEmpty=1, all outputs 0. Push PCF=0x100, PCTargetF=0x120, taken=1 -> QueueEmpty=0 next cycle. BranchE=1 with BranchTakenE=1 -> MispredictE=0, UpdValid=1 next cycle with UpdBackward=0, UpdTaken=1.
- Mispredict not-taken: push PCF=0x200, PCTargetF=0x1F0, taken=0. Push two more entries. BranchE with BranchTakenE=1 -> MispredictE=1, RecoveryPCE=0x1F0 same cycle. Next cycle QueueEmpty=1, UpdBackward=1, UpdTaken=1.
- Mispredict taken: head PC=0xFFFFFFFC, taken=1, BranchTakenE=0 -> RecoveryPCE=0x00000000 (wrap).
- Fill DEPTH=4 entries -> QueueFull=1. 5th push alone -> dropped, OverflowErr=1. 5th push with simultaneous correct pop -> accepted, QueueFull stays 1, FIFO order preserved on subsequent pops.
- BranchE with empty queue -> MispredictE=0, no UpdValid, UnderflowErr=1. Mispredict concurrent with push -> push discarded, count=0, OverflowErr unchanged.
- Pointer wrap: 10 push/pop pairs with alternating outcomes. Verify the UpdTaken sequence matches, and check rst asserted mid-stream returns QueueEmpty=1 with no trailing UpdValid.

Source files
------------

// File: rtl/branch_pred_queue.sv
// In-order queue of fetch-stage branch predictions, resolved one at a time in execute.
// Flags mispredicts combinationally and emits a registered direction-predictor update record.
module branch_pred_queue #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  PredValidF,
    input  logic                  PredTakenF,
    input  logic [DATA_WIDTH-1:0] PCF,
    input  logic [DATA_WIDTH-1:0] PCTargetF,
    input  logic                  BranchE,
    input  logic                  BranchTakenE,
    output logic                  MispredictE,
    output logic [DATA_WIDTH-1:0] RecoveryPCE,
    output logic                  QueueFull,
    output logic                  QueueEmpty,
    output logic                  UpdValid,
    output logic                  UpdBackward,
    output logic                  UpdTaken,
    output logic                  OverflowErr,
    output logic                  UnderflowErr
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    // Entry storage carries no reset: only slots covered by count are ever read.
    logic                  taken_q    [DEPTH];
    logic                  backward_q [DEPTH];
    logic [DATA_WIDTH-1:0] pc_q       [DEPTH];
    logic [DATA_WIDTH-1:0] target_q   [DEPTH];

    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;

    logic upd_valid_q, upd_backward_q, upd_taken_q;
    logic overflow_q, underflow_q;

    logic                  head_valid;
    logic                  is_full;
    logic                  head_taken;
    logic                  head_backward;
    logic [DATA_WIDTH-1:0] head_pc;
    logic [DATA_WIDTH-1:0] head_target;
    logic                  mispredict;
    logic                  pop;
    logic                  push;
    logic                  overflow_set;
    logic                  underflow_set;
    logic [DATA_WIDTH-1:0] recovery_pc;

    always_comb begin
        head_valid    = (count_q != '0);
        is_full       = (count_q == CntFull);
        head_taken    = taken_q[head_q];
        head_backward = backward_q[head_q];
        head_pc       = pc_q[head_q];
        head_target   = target_q[head_q];

        pop           = BranchE & head_valid;
        mispredict    = pop & (head_taken != BranchTakenE);
        // A full queue still accepts a push when the head leaves in the same cycle.
        push          = PredValidF & (~is_full | pop) & ~mispredict;
        overflow_set  = PredValidF & is_full & ~pop;
        underflow_set = BranchE & ~head_valid;

        recovery_pc = '0;
        if (head_valid) begin
            recovery_pc = head_taken ? head_pc + DATA_WIDTH'(4) : head_target;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (mispredict) begin
            // Everything behind the head is wrong-path: collapse to empty at the tail.
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (pop) begin
                head_d = head_q + PtrW'(1);
            end
            if (push) begin
                tail_d = tail_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            upd_valid_q    <= 1'b0;
            upd_backward_q <= 1'b0;
            upd_taken_q    <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            upd_valid_q <= pop;
            if (pop) begin
                upd_backward_q <= head_backward;
                upd_taken_q    <= BranchTakenE;
            end
            if (overflow_set) begin
                overflow_q <= 1'b1;
            end
            if (underflow_set) begin
                underflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            taken_q[tail_q]    <= PredTakenF;
            backward_q[tail_q] <= (PCTargetF < PCF);
            pc_q[tail_q]       <= PCF;
            target_q[tail_q]   <= PCTargetF;
        end
    end

    assign MispredictE  = mispredict;
    assign RecoveryPCE  = recovery_pc;
    assign QueueFull    = is_full;
    assign QueueEmpty   = ~head_valid;
    assign UpdValid     = upd_valid_q;
    assign UpdBackward  = upd_backward_q;
    assign UpdTaken     = upd_taken_q;
    assign OverflowErr  = overflow_q;
    assign UnderflowErr = underflow_q;

endmodule

// File: tb/tb_branch_pred_queue.sv
// Directed bench for branch_pred_queue: a queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_branch_pred_queue;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          PredValidF = 1'b0;
    logic          PredTakenF = 1'b0;
    logic [DW-1:0] PCF = '0;
    logic [DW-1:0] PCTargetF = '0;
    logic          BranchE = 1'b0;
    logic          BranchTakenE = 1'b0;
    logic          MispredictE;
    logic [DW-1:0] RecoveryPCE;
    logic          QueueFull, QueueEmpty;
    logic          UpdValid, UpdBackward, UpdTaken;
    logic          OverflowErr, UnderflowErr;

    int total = 0;
    int bad   = 0;

    branch_pred_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .PredValidF  (PredValidF),
        .PredTakenF  (PredTakenF),
        .PCF         (PCF),
        .PCTargetF   (PCTargetF),
        .BranchE     (BranchE),
        .BranchTakenE(BranchTakenE),
        .MispredictE (MispredictE),
        .RecoveryPCE (RecoveryPCE),
        .QueueFull   (QueueFull),
        .QueueEmpty  (QueueEmpty),
        .UpdValid    (UpdValid),
        .UpdBackward (UpdBackward),
        .UpdTaken    (UpdTaken),
        .OverflowErr (OverflowErr),
        .UnderflowErr(UnderflowErr)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: in-order list of outstanding predictions.
    typedef struct {
        logic          taken;
        logic          backward;
        logic [DW-1:0] pc;
        logic [DW-1:0] target;
    } ent_t;

    ent_t mq[$];
    logic m_uv = 1'b0, m_ub = 1'b0, m_ut = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

    always @(negedge clk) begin
        logic          empty, e_mis, pop, was_full;
        logic [DW-1:0] e_rec;
        ent_t          e;
        if (rst) begin
            mq.delete();
            m_uv = 1'b0; m_ub = 1'b0; m_ut = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        end
        empty = (mq.size() == 0);
        e_mis = 1'b0;
        e_rec = '0;
        if (!empty) begin
            e_rec = mq[0].taken ? mq[0].pc + 32'd4 : mq[0].target;
            e_mis = BranchE && (mq[0].taken != BranchTakenE);
        end
        chk1("m_mispredict", MispredictE, e_mis);
        chk32("m_recovery_pc", RecoveryPCE, e_rec);
        chk1("m_full", QueueFull, mq.size() == DEPTH);
        chk1("m_empty", QueueEmpty, empty);
        chk1("m_upd_valid", UpdValid, m_uv);
        if (m_uv) begin
            chk1("m_upd_backward", UpdBackward, m_ub);
            chk1("m_upd_taken", UpdTaken, m_ut);
        end
        chk1("m_overflow", OverflowErr, m_ovf);
        chk1("m_underflow", UnderflowErr, m_unf);

        if (!rst) begin
            pop      = BranchE && !empty;
            was_full = (mq.size() == DEPTH);
            m_uv     = pop;
            if (pop) begin
                m_ub = mq[0].backward;
                m_ut = BranchTakenE;
            end
            if (BranchE && empty) m_unf = 1'b1;
            if (e_mis) begin
                mq.delete();
            end else begin
                if (pop) void'(mq.pop_front());
                if (PredValidF) begin
                    if (!was_full || pop) begin
                        e.taken    = PredTakenF;
                        e.backward = PCTargetF < PCF;
                        e.pc       = PCF;
                        e.target   = PCTargetF;
                        mq.push_back(e);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
        end
    end

    // One clock cycle: drive after the rising edge, return just after the falling edge.
    task automatic cyc(input logic pv, input logic pt, input logic [DW-1:0] pc,
                       input logic [DW-1:0] tgt, input logic be, input logic bt);
        @(posedge clk); #1;
        PredValidF   = pv;
        PredTakenF   = pt;
        PCF          = pc;
        PCTargetF    = tgt;
        BranchE      = be;
        BranchTakenE = bt;
        @(negedge clk); #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] pc;
        idle();
        idle();
        chk1("rst_empty", QueueEmpty, 1'b1);
        chk1("rst_full", QueueFull, 1'b0);
        chk1("rst_upd_valid", UpdValid, 1'b0);
        chk1("rst_mispredict", MispredictE, 1'b0);
        chk32("rst_recovery", RecoveryPCE, 32'h0);
        chk1("rst_ovf", OverflowErr, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;

        // Correct taken prediction.
        cyc(1'b1, 1'b1, 32'h100, 32'h120, 1'b0, 1'b0);
        idle();
        chk1("t1_not_empty", QueueEmpty, 1'b0);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
        chk1("t1_no_mis", MispredictE, 1'b0);
        idle();
        chk1("t1_upd_valid", UpdValid, 1'b1);
        chk1("t1_upd_back", UpdBackward, 1'b0);
        chk1("t1_upd_taken", UpdTaken, 1'b1);

        // Not-taken mispredict flushes younger entries.
        cyc(1'b1, 1'b0, 32'h200, 32'h1F0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 32'h300, 32'h340, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 32'h400, 32'h380, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
        chk1("t2_mis", MispredictE, 1'b1);
        chk32("t2_recovery", RecoveryPCE, 32'h1F0);
        idle();
        chk1("t2_empty", QueueEmpty, 1'b1);
        chk1("t2_upd_back", UpdBackward, 1'b1);
        chk1("t2_upd_taken", UpdTaken, 1'b1);

        // Taken mispredict with PC+4 wrapping to zero.
        cyc(1'b1, 1'b1, 32'hFFFF_FFFC, 32'h10, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        chk1("t3_mis", MispredictE, 1'b1);
        chk32("t3_recovery_wrap", RecoveryPCE, 32'h0);
        idle();

        // Mispredict with a concurrent push: push discarded, no overflow.
        cyc(1'b1, 1'b1, 32'h7000, 32'h7100, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 32'h8000, 32'h8100, 1'b1, 1'b0);
        chk1("t4_mis", MispredictE, 1'b1);
        idle();
        chk1("t4_empty", QueueEmpty, 1'b1);
        chk1("t4_ovf_clear", OverflowErr, 1'b0);

        // Fill, overflow, then push+pop while full.
        cyc(1'b1, 1'b1, 32'h1000, 32'h1100, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 32'h2000, 32'h1F00, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 32'h3000, 32'h3100, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 32'h4000, 32'h3F00, 1'b0, 1'b0);
        idle();
        chk1("t5_full", QueueFull, 1'b1);
        cyc(1'b1, 1'b1, 32'h5000, 32'h5100, 1'b0, 1'b0);
        idle();
        chk1("t5_ovf", OverflowErr, 1'b1);
        chk1("t5_still_full", QueueFull, 1'b1);
        cyc(1'b1, 1'b1, 32'h6000, 32'h6100, 1'b1, 1'b1);
        chk1("t5_pushpop_no_mis", MispredictE, 1'b0);
        idle();
        chk1("t5_full_after_pushpop", QueueFull, 1'b1);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        chk32("t5_head_b", RecoveryPCE, 32'h1F00);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
        chk32("t5_head_c", RecoveryPCE, 32'h3004);
        chk1("t5_b_backward", UpdBackward, 1'b1);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        chk32("t5_head_d", RecoveryPCE, 32'h3F00);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
        chk32("t5_head_f", RecoveryPCE, 32'h6004);
        idle();
        chk1("t5_drained", QueueEmpty, 1'b1);

        // Underflow.
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
        chk1("t6_no_mis", MispredictE, 1'b0);
        idle();
        chk1("t6_no_upd", UpdValid, 1'b0);
        chk1("t6_unf", UnderflowErr, 1'b1);

        // Pointer wrap: overlapped push/pop with alternating outcomes.
        cyc(1'b1, 1'b0, 32'h9000, 32'h9040, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            pc = 32'h9000 + 32'(i * 16);
            cyc(i < 10, i[0], pc, pc + 32'h40, 1'b1, 1'((i - 1) % 2));
            chk1("t7_no_mis", MispredictE, 1'b0);
            if (i >= 2) begin
                chk1("t7_upd_valid", UpdValid, 1'b1);
                chk1("t7_upd_taken", UpdTaken, 1'((i - 2) % 2));
            end
        end
        idle();
        chk1("t7_last_taken", UpdTaken, 1'b1);
        chk1("t7_empty", QueueEmpty, 1'b1);

        // Reset mid-stream, asserted during a pop cycle.
        cyc(1'b1, 1'b1, 32'hA000, 32'hA100, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 32'hB000, 32'hA000, 1'b0, 1'b0);
        @(posedge clk); #1;
        PredValidF   = 1'b0;
        BranchE      = 1'b1;
        BranchTakenE = 1'b1;
        rst          = 1'b1;
        @(negedge clk); #1;
        @(posedge clk); #1;
        rst     = 1'b0;
        BranchE = 1'b0;
        @(negedge clk); #1;
        chk1("t8_empty", QueueEmpty, 1'b1);
        chk1("t8_no_upd", UpdValid, 1'b0);
        chk1("t8_unf_clear", UnderflowErr, 1'b0);
        idle();
        chk1("t8_no_trailing_upd", UpdValid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
